// File: rtl/apb_master_bridge.sv
// Single-clock APB requester: accepts one user command at a time and runs it
// through SETUP/ACCESS on one of NUM_SLAVES completers, reporting via a done pulse.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             transfer,
    input  logic                             READ_WRITE,
    input  logic [ADDR_WIDTH-1:0]            apb_write_paddr,
    input  logic [DATA_WIDTH-1:0]            apb_write_data,
    input  logic [DATA_WIDTH/8-1:0]          apb_write_strb,
    input  logic [ADDR_WIDTH-1:0]            apb_read_paddr,
    output logic [DATA_WIDTH-1:0]            apb_read_data_out,
    output logic                             PSLVERR,
    output logic                             done,
    output logic                             busy,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
    input  logic [NUM_SLAVES-1:0]            s_pready,
    input  logic [NUM_SLAVES-1:0]            s_pslverr,
    output logic [1:0]                       state_dbg
);
    localparam int SEL_BITS  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    tmo_cnt;
    logic                    comp_pending;
    logic                    err_stage;
    logic                    rd_load;
    logic [DATA_WIDTH-1:0]   rdata_stage;

    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [SEL_BITS-1:0]     cmd_idx;
    logic [NUM_SLAVES-1:0]   cmd_psel;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    complete;
    logic                    comp_err;
    logic                    comp_rd;
    logic                    take;

    assign state_dbg = state;

    // An out-of-range index matches no PSEL bit, so an all-zero PSEL in SETUP
    // is exactly the decode-error case; the completer mux is an AND-OR on PSEL.
    always_comb begin
        cmd_addr  = READ_WRITE ? apb_read_paddr : apb_write_paddr;
        cmd_idx   = cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
        cmd_psel  = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            cmd_psel[i] = (cmd_idx == SEL_BITS'(i));
            if (PSEL[i]) begin
                sel_rdata = sel_rdata | s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        sel_ready = |(PSEL & s_pready);
        sel_err   = |(PSEL & s_pslverr);
    end

    always_comb begin
        complete = 1'b0;
        comp_err = 1'b0;
        comp_rd  = 1'b0;
        case (state)
            SETUP: begin
                if (PSEL == '0) begin
                    complete = 1'b1;
                    comp_err = 1'b1;
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    complete = 1'b1;
                    comp_err = sel_err;
                    comp_rd  = !PWRITE && !sel_err;
                end else if (tmo_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
                    complete = 1'b1;
                    comp_err = 1'b1;
                end
            end
            default: ;
        endcase
        // Handshake: a command is taken on any edge where transfer=1 and the
        // bridge is IDLE or completing; done rises one cycle after completion.
        take = transfer && ((state == IDLE) || complete);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state             <= IDLE;
            busy              <= 1'b0;
            PSEL              <= '0;
            PENABLE           <= 1'b0;
            PWRITE            <= 1'b0;
            PADDR             <= '0;
            PWDATA            <= '0;
            PSTRB             <= '0;
            apb_read_data_out <= '0;
            PSLVERR           <= 1'b0;
            done              <= 1'b0;
            tmo_cnt           <= '0;
            comp_pending      <= 1'b0;
            err_stage         <= 1'b0;
            rd_load           <= 1'b0;
            rdata_stage       <= '0;
        end else begin
            // Result is staged so a following back-to-back completion cannot
            // overwrite PSLVERR/read data before its done pulse is seen.
            done         <= comp_pending;
            comp_pending <= complete;
            if (comp_pending) begin
                PSLVERR <= err_stage;
                if (rd_load) begin
                    apb_read_data_out <= rdata_stage;
                end
            end
            if (complete) begin
                err_stage   <= comp_err;
                rd_load     <= comp_rd;
                rdata_stage <= sel_rdata;
            end

            if (take) begin
                state   <= SETUP;
                busy    <= 1'b1;
                PSEL    <= cmd_psel;
                PENABLE <= 1'b0;
                PWRITE  <= !READ_WRITE;
                PADDR   <= cmd_addr;
                PWDATA  <= apb_write_data;
                PSTRB   <= READ_WRITE ? '0 : apb_write_strb;
                tmo_cnt <= '0;
            end else if (!complete && state == SETUP) begin
                state   <= ACCESS;
                PENABLE <= 1'b1;
            end else if (!complete && state == ACCESS) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                state   <= IDLE;
                busy    <= 1'b0;
                PSEL    <= '0;
                PENABLE <= 1'b0;
                PSTRB   <= '0;
                tmo_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized scoreboard bench for apb_master_bridge (3 completers, 16-bit data, TIMEOUT=4).
module tb_apb_master_bridge;
    localparam int AW  = 9;
    localparam int DW  = 16;
    localparam int NS  = 3;
    localparam int TMO = 4;

    logic            PCLK;
    logic            PRESETn;
    logic            transfer;
    logic            READ_WRITE;
    logic [AW-1:0]   apb_write_paddr;
    logic [DW-1:0]   apb_write_data;
    logic [DW/8-1:0] apb_write_strb;
    logic [AW-1:0]   apb_read_paddr;
    logic [DW-1:0]   apb_read_data_out;
    logic            PSLVERR;
    logic            done;
    logic            busy;
    logic [NS-1:0]   PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW/8-1:0] PSTRB;
    logic [NS*DW-1:0] s_prdata;
    logic [NS-1:0]   s_pready;
    logic [NS-1:0]   s_pslverr;
    logic [1:0]      state_dbg;

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT(TMO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_write_strb(apb_write_strb), .apb_read_paddr(apb_read_paddr),
        .apb_read_data_out(apb_read_data_out), .PSLVERR(PSLVERR), .done(done),
        .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .s_prdata(s_prdata), .s_pready(s_pready),
        .s_pslverr(s_pslverr), .state_dbg(state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int unsigned cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0]     at;
        logic [NS-1:0]   psel;
        logic [AW-1:0]   paddr;
        logic            pwrite;
        logic [DW-1:0]   pwdata;
        logic [DW/8-1:0] pstrb;
    } apb_exp_t;

    typedef struct packed {
        logic [31:0]   at;
        logic          err;
        logic [DW-1:0] data;
    } done_exp_t;

    apb_exp_t    apb_q[$];
    done_exp_t   exp_q[$];
    apb_exp_t    cur = '0;
    logic [DW-1:0] exp_data = '0;
    int unsigned free_edge = 0;
    int unsigned busy_from = 0;
    int unsigned busy_to   = 0;
    logic        busy_exp;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                    apb_read_data_out, PSLVERR, done, busy, state_dbg});
    endfunction

    // Completer behaviour chosen by the address: [2:0]=wait states, [3]=error.
    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a, input logic [1:0] k);
        return {a[7:0] ^ {6'd0, k} ^ 8'h5A, ~a[7:0]};
    endfunction

    // ---------------- completers ----------------
    int acc_cnt = 0;
    always @(negedge PCLK) begin
        s_pready  = 3'($urandom);
        s_pslverr = 3'($urandom);
        s_prdata  = 48'({$urandom, $urandom});
        if (PENABLE) begin
            for (int k = 0; k < NS; k++) begin
                if (PSEL[k]) begin
                    s_pready[k]          = (acc_cnt == int'(PADDR[2:0]));
                    s_pslverr[k]         = s_pready[k] ? PADDR[3] : 1'($urandom);
                    s_prdata[k*DW +: DW] = rdata_of(PADDR, 2'(k));
                end
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge PCLK) begin
        if (PRESETn) begin
            busy_exp = (cyc >= busy_from) && (cyc < busy_to);
            chk("busy", 64'(busy), 64'(busy_exp));
            if (PSEL != '0 && !PENABLE) begin
                if (apb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_setup: got PSEL=%b at cycle %0d, want no select", PSEL, cyc);
                end else begin
                    cur = apb_q.pop_front();
                    chk("setup_cycle", 64'(cyc), 64'(cur.at));
                    chk("psel", 64'(PSEL), 64'(cur.psel));
                    chk("paddr", 64'(PADDR), 64'(cur.paddr));
                    chk("pwrite", 64'(PWRITE), 64'(cur.pwrite));
                    chk("pwdata", 64'(PWDATA), 64'(cur.pwdata));
                    chk("pstrb", 64'(PSTRB), 64'(cur.pstrb));
                end
            end else if (PENABLE) begin
                chk("access_hold", 64'({PSEL, PADDR, PWRITE, PWDATA, PSTRB}),
                    64'({cur.psel, cur.paddr, cur.pwrite, cur.pwdata, cur.pstrb}));
            end else if (!busy_exp) begin
                chk("idle_outputs", 64'({PSEL, PENABLE, PSTRB}), 64'(0));
            end

            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, want none", cyc);
                end else begin
                    done_exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.at));
                    chk("pslverr", 64'(PSLVERR), 64'(e.err));
                    chk("read_data", 64'(apb_read_data_out), 64'(e.data));
                end
            end else if (exp_q.size() != 0 && cyc >= exp_q[0].at) begin
                total++;
                bad++;
                $display("FAIL missing_done: got done=0 at cycle %0d, want done=1", cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic run_cmd(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW/8-1:0] st, input int gap, input bit abort);
        int unsigned acc;
        int unsigned comp;
        int unsigned w;
        logic [1:0]  idx;
        logic        err;
        logic        upd;
        apb_exp_t    a;
        done_exp_t   d;
        if (gap > 0) begin
            transfer = 1'b0;
            while (cyc < free_edge) @(negedge PCLK);
            repeat (gap) @(negedge PCLK);
        end
        acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;

        READ_WRITE      = rd;
        apb_read_paddr  = rd ? addr : 9'($urandom);
        apb_write_paddr = rd ? 9'($urandom) : addr;
        apb_write_data  = wd;
        apb_write_strb  = st;
        transfer        = 1'b1;

        idx = addr[AW-1 -: 2];
        w   = int'(addr[2:0]);
        upd = 1'b0;
        if (idx >= 2'(NS)) begin
            comp = acc + 1;
            err  = 1'b1;
        end else begin
            a.at     = acc;
            a.psel   = 3'b001 << idx;
            a.paddr  = addr;
            a.pwrite = !rd;
            a.pwdata = wd;
            a.pstrb  = rd ? 2'b00 : st;
            apb_q.push_back(a);
            if (w < TMO) begin
                comp = acc + 2 + w;
                err  = addr[3];
                upd  = rd && !err;
            end else begin
                comp = acc + 1 + TMO;
                err  = 1'b1;
            end
        end
        if (upd) exp_data = rdata_of(addr, idx);
        if (!abort) begin
            d.at   = comp + 1;
            d.err  = err;
            d.data = exp_data;
            exp_q.push_back(d);
        end
        if (acc != free_edge) busy_from = acc;
        busy_to   = comp;
        free_edge = comp;

        while (cyc < acc) @(negedge PCLK);

        if (abort) begin
            transfer = 1'b0;
            repeat (2) @(negedge PCLK);
            #2 PRESETn = 1'b0;
            #1 chk("async_reset", all_outs(), 64'(0));
            exp_data  = '0;
            free_edge = 0;
            busy_from = 0;
            busy_to   = 0;
            apb_q.delete();
            exp_q.delete();
            @(negedge PCLK);
            #1 PRESETn = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        PRESETn         = 1'b0;
        transfer        = 1'b0;
        READ_WRITE      = 1'b0;
        apb_write_paddr = '0;
        apb_write_data  = '0;
        apb_write_strb  = '0;
        apb_read_paddr  = '0;
        repeat (2) @(negedge PCLK);
        chk("reset_outputs", all_outs(), 64'(0));
        @(negedge PCLK);
        #1 PRESETn = 1'b1;

        run_cmd(1'b0, 9'h000, 16'hA5A5, 2'b01, 0, 1'b0);
        run_cmd(1'b1, 9'h082, 16'h1111, 2'b11, 0, 1'b0);
        run_cmd(1'b1, 9'h10B, 16'h2222, 2'b11, 0, 1'b0);
        run_cmd(1'b1, 9'h1C0, 16'h3333, 2'b10, 0, 1'b0);
        run_cmd(1'b1, 9'h086, 16'h4444, 2'b01, 1, 1'b0);
        run_cmd(1'b0, 9'h103, 16'hBEEF, 2'b10, 0, 1'b0);
        run_cmd(1'b1, 9'h004, 16'h5555, 2'b11, 0, 1'b0);
        run_cmd(1'b0, 9'h180, 16'h6666, 2'b11, 2, 1'b0);
        run_cmd(1'b0, 9'h010, 16'h0A0A, 2'b01, 3, 1'b0);
        run_cmd(1'b0, 9'h090, 16'h0B0B, 2'b10, 0, 1'b0);
        run_cmd(1'b0, 9'h110, 16'h0C0C, 2'b11, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            run_cmd(1'($urandom_range(0, 1)), 9'($urandom), 16'($urandom), 2'($urandom),
                    ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)), 1'b0);
        end

        run_cmd(1'b1, 9'h087, 16'h7777, 2'b00, 1, 1'b1);
        run_cmd(1'b1, 9'h0A1, 16'h8888, 2'b00, 1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            run_cmd(1'($urandom_range(0, 1)), 9'($urandom), 16'($urandom), 2'($urandom),
                    ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)), 1'b0);
        end

        transfer = 1'b0;
        while (cyc < free_edge + 3) @(negedge PCLK);
        chk("done_queue_drained", 64'(exp_q.size()), 64'(0));
        chk("setup_queue_drained", 64'(apb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
